// File: rtl/pipeline_ctrl_sequencer_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_sequencer_if
// Bundles the hazard/debug requests going into the pipeline control sequencer
// and the stage controls plus performance counters coming back out of it.
//   master : hazard unit / debug unit / pipeline registers side
//            (drives i_*, observes o_*)
//   slave  : the sequencer itself (observes i_*, drives o_*)
// Clock and reset are plain ports on the sequencer, not part of this bundle.
// -----------------------------------------------------------------------------
interface pipeline_ctrl_sequencer_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 i_stall;
    logic                 i_flush;
    logic                 i_halt;
    logic                 i_resume;
    logic                 i_step;
    logic                 i_cnt_clr;
    logic                 o_pc_we;
    logic                 o_if_id_we;
    logic                 o_if_id_flush;
    logic                 o_id_ex_bubble;
    logic                 o_draining;
    logic                 o_halted;
    logic [CNT_WIDTH-1:0] o_stall_cnt;
    logic [CNT_WIDTH-1:0] o_flush_cnt;

    modport master (
        output i_stall, i_flush, i_halt, i_resume, i_step, i_cnt_clr,
        input  o_pc_we, o_if_id_we, o_if_id_flush, o_id_ex_bubble,
               o_draining, o_halted, o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_stall, i_flush, i_halt, i_resume, i_step, i_cnt_clr,
        output o_pc_we, o_if_id_we, o_if_id_flush, o_id_ex_bubble,
               o_draining, o_halted, o_stall_cnt, o_flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_sequencer
// Turns hazard-unit stall/flush/halt requests into per-stage pipeline register
// controls and owns the run/halt state machine (drain after HALT, halted hold,
// debug resume and single-step). Keeps saturating stall/flush cycle counters.
//
// Ports:
//   i_clk    - system clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   bus      - pipeline_ctrl_sequencer_if.slave
//              in : i_stall, i_flush, i_halt, i_resume, i_step, i_cnt_clr
//              out: o_pc_we, o_if_id_we, o_if_id_flush, o_id_ex_bubble
//                   (combinational, same cycle as the hazard),
//                   o_draining, o_halted (decoded from the state register),
//                   o_stall_cnt, o_flush_cnt (saturating counters)
// -----------------------------------------------------------------------------
module pipeline_ctrl_sequencer #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    pipeline_ctrl_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } state_t;

    localparam logic [3:0]           DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_r;
    state_t               state_nxt_s;
    logic [3:0]           drain_cnt_r;
    logic [3:0]           drain_cnt_nxt_s;
    logic                 pc_we_s;
    logic                 if_id_we_s;
    logic                 if_id_flush_s;
    logic                 id_ex_bubble_s;
    logic                 stall_inc_s;
    logic                 flush_inc_s;
    logic [CNT_WIDTH-1:0] stall_cnt_r;
    logic [CNT_WIDTH-1:0] flush_cnt_r;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    // State and drain-counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= RUN;
            drain_cnt_r <= 4'd0;
        end else begin
            state_r     <= state_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
        end
    end

    // Next-state logic and stage controls from current state and inputs.
    always_comb begin
        state_nxt_s     = state_r;
        drain_cnt_nxt_s = drain_cnt_r;
        pc_we_s         = 1'b0;
        if_id_we_s      = 1'b0;
        if_id_flush_s   = 1'b0;
        id_ex_bubble_s  = 1'b0;
        stall_inc_s     = 1'b0;
        flush_inc_s     = 1'b0;
        case (state_r)
            RUN: begin
                if (bus.i_flush) begin
                    // A HALT sitting in ID on the wrong path is squashed here.
                    pc_we_s        = 1'b1;
                    if_id_we_s     = 1'b1;
                    if_id_flush_s  = 1'b1;
                    id_ex_bubble_s = 1'b1;
                    flush_inc_s    = 1'b1;
                end else if (bus.i_halt) begin
                    // IF/ID is held so the HALT is re-decoded after resume.
                    id_ex_bubble_s  = 1'b1;
                    drain_cnt_nxt_s = DRAIN_LOAD;
                    state_nxt_s     = DRAIN;
                end else if (bus.i_stall) begin
                    id_ex_bubble_s = 1'b1;
                    stall_inc_s    = 1'b1;
                end else begin
                    pc_we_s    = 1'b1;
                    if_id_we_s = 1'b1;
                end
            end
            DRAIN: begin
                id_ex_bubble_s = 1'b1;
                if (drain_cnt_r == 4'd0) begin
                    state_nxt_s = HALTED;
                end else begin
                    drain_cnt_nxt_s = drain_cnt_r - 4'd1;
                end
            end
            HALTED: begin
                id_ex_bubble_s = 1'b1;
                if (bus.i_resume) begin
                    state_nxt_s = RUN;
                end else if (bus.i_step) begin
                    state_nxt_s = STEP;
                end else begin
                    state_nxt_s = HALTED;
                end
            end
            STEP: begin
                pc_we_s         = 1'b1;
                if_id_we_s      = 1'b1;
                if_id_flush_s   = bus.i_flush;
                drain_cnt_nxt_s = DRAIN_LOAD;
                state_nxt_s     = DRAIN;
            end
            default: begin
                state_nxt_s     = RUN;
                drain_cnt_nxt_s = 4'd0;
            end
        endcase
    end

    // Performance counters; a clear beats an increment in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else if (bus.i_cnt_clr) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (stall_inc_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (flush_inc_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
        end
    end

    // Combinational controls are forced low while reset is held.
    assign bus.o_pc_we        = i_rst_n & pc_we_s;
    assign bus.o_if_id_we     = i_rst_n & if_id_we_s;
    assign bus.o_if_id_flush  = i_rst_n & if_id_flush_s;
    assign bus.o_id_ex_bubble = i_rst_n & id_ex_bubble_s;
    assign bus.o_draining     = (state_r == DRAIN);
    assign bus.o_halted       = (state_r == HALTED);
    assign bus.o_stall_cnt    = stall_cnt_r;
    assign bus.o_flush_cnt    = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl_sequencer
// Directed vectors with hand-computed expectations for the pipeline control
// sequencer. Inputs change 1 time unit after the rising edge and outputs are
// sampled 3 time units later, well before the next edge.
// Control vector packing: {pc_we, if_id_we, if_id_flush, id_ex_bubble,
//                          draining, halted}
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl_sequencer;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    pipeline_ctrl_sequencer_if #(.CNT_WIDTH(16)) bus ();

    pipeline_ctrl_sequencer #(
        .DRAIN_CYCLES (3),
        .CNT_WIDTH    (16)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] C_ZERO   = 6'b000000;
    localparam logic [5:0] C_RUN    = 6'b110000;
    localparam logic [5:0] C_STALL  = 6'b000100;
    localparam logic [5:0] C_FLUSH  = 6'b111100;
    localparam logic [5:0] C_DRAIN  = 6'b000110;
    localparam logic [5:0] C_HALTED = 6'b000101;
    localparam logic [5:0] C_STEP   = 6'b110000;
    localparam logic [5:0] C_STEPFL = 6'b111000;

    // Single comparison point: counts and reports mismatches.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic [5:0] exp);
        check_val(tag, {26'd0, bus.o_pc_we, bus.o_if_id_we, bus.o_if_id_flush,
                        bus.o_id_ex_bubble, bus.o_draining, bus.o_halted}, {26'd0, exp});
    endtask

    // Input vector: {stall, flush, halt, resume, step, cnt_clr}
    task automatic drive(input logic [5:0] v);
        bus.i_stall   = v[5];
        bus.i_flush   = v[4];
        bus.i_halt    = v[3];
        bus.i_resume  = v[2];
        bus.i_step    = v[1];
        bus.i_cnt_clr = v[0];
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;

        // Reset: outputs gated low even with an idle RUN-looking input set.
        drive(6'b000000);
        check_ctrl("reset_ctrl", C_ZERO);
        check_val("reset_stall_cnt", {16'd0, bus.o_stall_cnt}, 32'd0);
        check_val("reset_flush_cnt", {16'd0, bus.o_flush_cnt}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Five hazard-free RUN cycles.
        for (int i = 0; i < 5; i++) begin
            drive(6'b000000);
            check_ctrl($sformatf("run_idle_%0d", i), C_RUN);
            tick();
        end
        check_val("run_stall_cnt", {16'd0, bus.o_stall_cnt}, 32'd0);
        check_val("run_flush_cnt", {16'd0, bus.o_flush_cnt}, 32'd0);

        // Two stall cycles, then normal again.
        for (int i = 0; i < 2; i++) begin
            drive(6'b100000);
            check_ctrl($sformatf("stall_%0d", i), C_STALL);
            tick();
        end
        drive(6'b000000);
        check_ctrl("after_stall", C_RUN);
        check_val("stall_cnt_2", {16'd0, bus.o_stall_cnt}, 32'd2);

        // Flush and halt together: flush wins, no drain.
        tick();
        drive(6'b011000);
        check_ctrl("flush_and_halt", C_FLUSH);
        tick();
        drive(6'b000000);
        check_ctrl("after_flush_run", C_RUN);
        check_val("flush_cnt_1", {16'd0, bus.o_flush_cnt}, 32'd1);
        tick();

        // HALT pulse: bubble in the halt cycle, three drain cycles, then HALTED.
        drive(6'b001000);
        check_ctrl("halt_cycle", C_STALL);
        tick();
        drive(6'b000000);
        check_ctrl("drain_0", C_DRAIN);
        tick();
        drive(6'b110100);   // stall, flush, resume all ignored in DRAIN
        check_ctrl("drain_1_ignore", C_DRAIN);
        tick();
        drive(6'b000010);   // step ignored in DRAIN
        check_ctrl("drain_2", C_DRAIN);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(i == 1 ? 6'b110000 : 6'b000000);
            check_ctrl($sformatf("halted_%0d", i), C_HALTED);
            tick();
        end
        check_val("halted_stall_cnt", {16'd0, bus.o_stall_cnt}, 32'd2);
        check_val("halted_flush_cnt", {16'd0, bus.o_flush_cnt}, 32'd1);

        // Single step: request seen in HALTED, one fetch cycle (with flush), redrain.
        drive(6'b000010);
        check_ctrl("step_req", C_HALTED);
        tick();
        drive(6'b010000);
        check_ctrl("step_cycle_flush", C_STEPFL);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(6'b000000);
            check_ctrl($sformatf("step_drain_%0d", i), C_DRAIN);
            tick();
        end
        drive(6'b000000);
        check_ctrl("step_halted", C_HALTED);
        check_val("step_flush_cnt", {16'd0, bus.o_flush_cnt}, 32'd1);
        tick();

        // Plain step without flush.
        drive(6'b000010);
        tick();
        drive(6'b000000);
        check_ctrl("step_cycle", C_STEP);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        drive(6'b000000);
        check_ctrl("step2_halted", C_HALTED);
        tick();

        // Resume and step together: resume wins.
        drive(6'b000110);
        check_ctrl("resume_req", C_HALTED);
        tick();
        drive(6'b000000);
        check_ctrl("resumed_run", C_RUN);
        tick();

        // Clear counters, then drive stall counter to 0xFFFE and saturate.
        drive(6'b000001);
        tick();
        drive(6'b000000);
        check_val("clr_stall_cnt", {16'd0, bus.o_stall_cnt}, 32'd0);
        check_val("clr_flush_cnt", {16'd0, bus.o_flush_cnt}, 32'd0);
        drive(6'b100000);
        for (int i = 0; i < 65534; i++) begin
            tick();
        end
        drive(6'b100000);
        check_val("stall_cnt_fffe", {16'd0, bus.o_stall_cnt}, 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        drive(6'b100000);
        check_val("stall_cnt_sat", {16'd0, bus.o_stall_cnt}, 32'h0000_FFFF);
        check_ctrl("stall_during_sat", C_STALL);
        drive(6'b100001);
        tick();
        drive(6'b000000);
        check_val("clr_beats_inc", {16'd0, bus.o_stall_cnt}, 32'd0);

        // Flush once, then halt and drop reset in the middle of DRAIN.
        tick();
        drive(6'b010000);
        tick();
        drive(6'b001000);
        check_val("pre_rst_flush_cnt", {16'd0, bus.o_flush_cnt}, 32'd1);
        tick();
        drive(6'b000000);
        check_ctrl("pre_rst_drain", C_DRAIN);
        rst_n = 1'b0;
        #1;
        check_ctrl("mid_drain_rst_ctrl", C_ZERO);
        check_val("mid_drain_rst_flush_cnt", {16'd0, bus.o_flush_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        drive(6'b000000);
        check_ctrl("post_rst_run", C_RUN);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
